// File: rtl/day2_range_scheduler_pkg.sv
// Shared types for the range scheduler: job-level FSM states and per-worker slot states.
package day2_range_scheduler_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } sched_state_t;

    typedef enum logic [1:0] {
        WK_FREE,
        WK_ASSIGNED,
        WK_PENDING
    } wk_state_t;

endpackage

// File: rtl/day2_range_scheduler_if.sv
// Range-input handshake plus worker dispatch/completion bus between loader, scheduler and worker array.
interface day2_range_scheduler_if #(
    parameter int unsigned W = 48,
    parameter int unsigned N = 8
);
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_start_id;
    logic [W-1:0]   in_end_id;
    logic           in_last;
    logic [N-1:0]   disp_valid;
    logic [W-1:0]   disp_start_id;
    logic [W-1:0]   disp_end_id;
    logic [N-1:0]   wk_done;
    logic [N*W-1:0] wk_sum;

    // Loader and worker array side.
    modport master (
        output in_valid, in_start_id, in_end_id, in_last, wk_done, wk_sum,
        input  in_ready, disp_valid, disp_start_id, disp_end_id
    );

    // Scheduler side.
    modport slave (
        input  in_valid, in_start_id, in_end_id, in_last, wk_done, wk_sum,
        output in_ready, disp_valid, disp_start_id, disp_end_id
    );
endinterface

// File: rtl/day2_range_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer; pointer moves past the grant.
module day2_range_scheduler_rr_arbiter #(
    parameter int unsigned N = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant_c
);
    localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_nx;
    logic [PTR_W-1:0] gidx;
    logic [N-1:0]     hi_mask;
    logic [N-1:0]     hi_req;

    // Prefer requesters at index >= ptr, otherwise wrap to the lowest requester.
    always_comb begin
        hi_mask = '0;
        for (int unsigned k = 0; k < N; k++) begin
            hi_mask[k] = (k >= 32'(ptr));
        end
        hi_req = req & hi_mask;
        if (hi_req != '0) begin
            grant_c = hi_req & (~hi_req + N'(1));
        end else begin
            grant_c = req & (~req + N'(1));
        end
        gidx = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (grant_c[k]) begin
                gidx = PTR_W'(k);
            end
        end
        ptr_nx = (gidx == PTR_W'(N - 1)) ? '0 : gidx + PTR_W'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= ptr_nx;
        end
    end
endmodule

// File: rtl/day2_range_scheduler.sv
// Schedules ID ranges onto a pool of range-checker workers and accumulates their partial sums into id_sum.
module day2_range_scheduler
    import day2_range_scheduler_pkg::*;
#(
    parameter int unsigned W           = 48,
    parameter int unsigned NUM_WORKERS = 8,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  en,
    day2_range_scheduler_if.slave bus,
    output logic [W-1:0]          id_sum,
    output logic                  done,
    output logic                  overflow,
    output logic                  proto_err,
    output logic [CNT_W-1:0]      range_count
);
    localparam int unsigned N = NUM_WORKERS;

    sched_state_t state;
    sched_state_t state_nx;
    logic         job_start;

    wk_state_t    wk_st     [N];
    wk_state_t    wk_st_nx  [N];
    logic [W-1:0] wk_lat    [N];
    logic [W-1:0] wk_lat_nx [N];

    logic [N-1:0] free_mask;
    logic [N-1:0] pend_mask;
    logic [N-1:0] tgt_oh;
    logic [N-1:0] grant;
    logic         stray;
    logic         accept;
    logic         dispatch;
    logic         drain;
    logic [W-1:0] drain_sum;
    logic [W:0]   sum_ext;

    logic [N-1:0] disp_valid_q;
    logic [W-1:0] disp_start_q;
    logic [W-1:0] disp_end_q;

    always_comb begin
        free_mask = '0;
        pend_mask = '0;
        for (int unsigned k = 0; k < N; k++) begin
            free_mask[k] = (wk_st[k] == WK_FREE);
            pend_mask[k] = (wk_st[k] == WK_PENDING);
        end
    end

    // Ready depends on registered state only; empty ranges never reserve a worker.
    assign bus.in_ready = (state == S_RUN) && (free_mask != '0);
    assign accept       = bus.in_valid && bus.in_ready;
    assign dispatch     = accept && (bus.in_start_id <= bus.in_end_id);
    assign tgt_oh       = free_mask & (~free_mask + N'(1));
    assign drain        = (grant != '0);

    day2_range_scheduler_rr_arbiter #(.N(N)) u_arb (
        .clock   (clock),
        .reset   (reset),
        .req     (pend_mask),
        .advance (drain),
        .grant_c (grant)
    );

    always_comb begin
        drain_sum = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (grant[k]) begin
                drain_sum = wk_lat[k];
            end
        end
    end

    assign sum_ext = {1'b0, id_sum} + {1'b0, drain_sum};

    // Per-worker slot transitions; a completion on a slot that is not ASSIGNED is a protocol error.
    always_comb begin
        stray = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            wk_st_nx[k]  = wk_st[k];
            wk_lat_nx[k] = wk_lat[k];
            if (grant[k]) begin
                wk_st_nx[k] = WK_FREE;
            end
            if (dispatch && tgt_oh[k]) begin
                wk_st_nx[k] = WK_ASSIGNED;
            end
            if (bus.wk_done[k]) begin
                if (wk_st[k] == WK_ASSIGNED) begin
                    wk_st_nx[k]  = WK_PENDING;
                    wk_lat_nx[k] = bus.wk_sum[k*W +: W];
                end else begin
                    stray = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nx  = state;
        job_start = 1'b0;
        case (state)
            S_IDLE: begin
                if (en) begin
                    state_nx  = S_RUN;
                    job_start = 1'b1;
                end
            end
            S_RUN: begin
                if (accept && bus.in_last) begin
                    state_nx = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (&free_mask) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                if (en) begin
                    state_nx  = S_RUN;
                    job_start = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            done         <= 1'b0;
            id_sum       <= '0;
            overflow     <= 1'b0;
            proto_err    <= 1'b0;
            range_count  <= '0;
            disp_valid_q <= '0;
            disp_start_q <= '0;
            disp_end_q   <= '0;
            for (int unsigned k = 0; k < N; k++) begin
                wk_st[k]  <= WK_FREE;
                wk_lat[k] <= '0;
            end
        end else begin
            state <= state_nx;
            done  <= (state_nx == S_DONE);
            for (int unsigned k = 0; k < N; k++) begin
                wk_st[k]  <= wk_st_nx[k];
                wk_lat[k] <= wk_lat_nx[k];
            end
            disp_valid_q <= dispatch ? tgt_oh : '0;
            if (dispatch) begin
                disp_start_q <= bus.in_start_id;
                disp_end_q   <= bus.in_end_id;
            end
            if (job_start) begin
                id_sum      <= '0;
                overflow    <= 1'b0;
                proto_err   <= 1'b0;
                range_count <= '0;
            end else begin
                if (drain) begin
                    id_sum <= sum_ext[W-1:0];
                    if (sum_ext[W]) begin
                        overflow <= 1'b1;
                    end
                end
                if (accept && (range_count != {CNT_W{1'b1}})) begin
                    range_count <= range_count + CNT_W'(1);
                end
            end
            if (stray) begin
                proto_err <= 1'b1;
            end
        end
    end

    assign bus.disp_valid    = disp_valid_q;
    assign bus.disp_start_id = disp_start_q;
    assign bus.disp_end_id   = disp_end_q;
endmodule

// File: tb/tb_day2_range_scheduler.sv
// Scoreboard bench for day2_range_scheduler: directed jobs, worker model, decoupled monitor.
module tb_day2_range_scheduler;
    localparam int unsigned W     = 48;
    localparam int unsigned NW    = 4;
    localparam int unsigned CNT_W = 16;

    typedef struct {
        logic [W-1:0] s;
        logic [W-1:0] e;
        int           wk;
    } exp_disp_t;

    typedef struct {
        logic [W-1:0]     sum;
        logic             ovf;
        logic [CNT_W-1:0] cnt;
    } exp_done_t;

    logic             clock = 1'b0;
    logic             reset;
    logic             en;
    logic [W-1:0]     id_sum;
    logic             done;
    logic             overflow;
    logic             proto_err;
    logic [CNT_W-1:0] range_count;

    int checks = 0;
    int errors = 0;

    exp_disp_t    disp_q[$];
    exp_done_t    done_q[$];
    logic [W-1:0] ret_q[$];
    logic [W-1:0] sum_q[$];
    bit           sum_track = 0;

    logic [NW-1:0] w_busy = '0;
    int            w_cnt[NW];
    logic [W-1:0]  w_ret[NW];
    int            lat = 5;
    bit            hold = 0;

    day2_range_scheduler_if #(.W(W), .N(NW)) bus ();

    day2_range_scheduler #(.W(W), .NUM_WORKERS(NW), .CNT_W(CNT_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .en          (en),
        .bus         (bus),
        .id_sum      (id_sum),
        .done        (done),
        .overflow    (overflow),
        .proto_err   (proto_err),
        .range_count (range_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Worker array model: each dispatched worker returns the queued sum after 'lat' cycles.
    initial begin
        bus.wk_done = '0;
        bus.wk_sum  = '0;
        forever begin
            @(posedge clock);
            #1;
            bus.wk_done = '0;
            for (int k = 0; k < NW; k++) begin
                if (w_busy[k]) begin
                    if (w_cnt[k] > 0) w_cnt[k]--;
                    if (w_cnt[k] == 0 && !hold) begin
                        bus.wk_done[k]        = 1'b1;
                        bus.wk_sum[k*W +: W]  = w_ret[k];
                        w_busy[k]             = 1'b0;
                    end
                end
            end
            for (int k = 0; k < NW; k++) begin
                if (bus.disp_valid[k]) begin
                    if (ret_q.size() != 0) w_ret[k] = ret_q.pop_front();
                    else w_ret[k] = '0;
                    w_busy[k] = 1'b1;
                    w_cnt[k]  = lat;
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a dispatch, a job completion or a new id_sum.
    logic         done_d = 1'b0;
    logic [W-1:0] prev_sum = '0;
    exp_disp_t    m_ed;
    exp_done_t    m_dd;
    logic [63:0]  m_oh;
    initial begin
        forever begin
            @(negedge clock);
            if (bus.disp_valid != '0) begin
                chk("disp_onehot", 64'($onehot(bus.disp_valid)), 64'(1));
                if (disp_q.size() == 0) begin
                    chk("disp_unexpected", 64'(bus.disp_valid), 64'(0));
                end else begin
                    m_ed = disp_q.pop_front();
                    chk("disp_start", 64'(bus.disp_start_id), 64'(m_ed.s));
                    chk("disp_end", 64'(bus.disp_end_id), 64'(m_ed.e));
                    if (m_ed.wk >= 0) begin
                        m_oh = 64'(1) << m_ed.wk;
                        chk("disp_target", 64'(bus.disp_valid), m_oh);
                    end
                end
            end
            if (done && !done_d) begin
                if (done_q.size() == 0) begin
                    chk("done_unexpected", 64'(done), 64'(0));
                end else begin
                    m_dd = done_q.pop_front();
                    chk("done_id_sum", 64'(id_sum), 64'(m_dd.sum));
                    chk("done_overflow", 64'(overflow), 64'(m_dd.ovf));
                    chk("done_range_count", 64'(range_count), 64'(m_dd.cnt));
                    chk("done_proto_err", 64'(proto_err), 64'(0));
                end
            end
            if (sum_track && id_sum != prev_sum) begin
                if (sum_q.size() == 0) chk("sum_unexpected", 64'(id_sum), 64'(prev_sum));
                else chk("drain_step_sum", 64'(id_sum), 64'(sum_q.pop_front()));
            end
            done_d   = done;
            prev_sum = id_sum;
        end
    end

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic pulse_en();
        @(negedge clock);
        en = 1'b1;
        @(negedge clock);
        en = 1'b0;
    endtask

    task automatic push_done(input logic [W-1:0] sum, input logic ovf, input int cnt);
        exp_done_t d;
        d.sum = sum;
        d.ovf = ovf;
        d.cnt = CNT_W'(cnt);
        done_q.push_back(d);
    endtask

    task automatic send(input logic [W-1:0] s, input logic [W-1:0] e, input bit last,
                        input int wk, input logic [W-1:0] ret);
        int n;
        exp_disp_t ed;
        @(negedge clock);
        bus.in_valid    = 1'b1;
        bus.in_start_id = s;
        bus.in_end_id   = e;
        bus.in_last     = last;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (!bus.in_ready) begin
            chk("accept_timeout", 64'(bus.in_ready), 64'(1));
            bus.in_valid = 1'b0;
            return;
        end
        if (s <= e) begin
            ed.s  = s;
            ed.e  = e;
            ed.wk = wk;
            disp_q.push_back(ed);
            ret_q.push_back(ret);
        end
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 300) begin
            @(negedge clock);
            n++;
        end
        chk("done_reached", 64'(done), 64'(1));
        @(negedge clock);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int n;
        reset           = 1'b1;
        en              = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_start_id = '0;
        bus.in_end_id   = '0;
        bus.in_last     = 1'b0;
        do_reset();

        // Reset state.
        @(negedge clock);
        chk("rst_id_sum", 64'(id_sum), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
        chk("rst_disp_valid", 64'(bus.disp_valid), 64'(0));
        chk("rst_range_count", 64'(range_count), 64'(0));

        // Single range 11:22, worker returns 33.
        lat = 5;
        pulse_en();
        chk("run_in_ready", 64'(bus.in_ready), 64'(1));
        push_done(W'(33), 1'b0, 1);
        send(W'(11), W'(22), 1'b1, 0, W'(33));
        @(negedge clock);
        chk("disp_latency", 64'(bus.disp_valid), 64'(1));
        wait_done();

        // Ten ranges over four workers; returns 1..10.
        do_reset();
        lat = 6;
        pulse_en();
        push_done(W'(55), 1'b0, 10);
        for (int i = 0; i < 10; i++) begin
            send(W'(i * 10), W'(i * 10 + 5), (i == 9), (i < 4) ? i : -1, W'(i + 1));
            if (i == 3) begin
                @(negedge clock);
                chk("in_ready_all_busy", 64'(bus.in_ready), 64'(0));
            end
        end
        wait_done();

        // Four completions in the same cycle, drained in round-robin order 0..3.
        do_reset();
        lat  = 1;
        hold = 1;
        pulse_en();
        push_done(W'(15), 1'b0, 4);
        send(W'(100), W'(101), 1'b0, 0, W'(1));
        send(W'(102), W'(103), 1'b0, 1, W'(2));
        send(W'(104), W'(105), 1'b0, 2, W'(4));
        send(W'(106), W'(107), 1'b1, 3, W'(8));
        sum_q.push_back(W'(1));
        sum_q.push_back(W'(3));
        sum_q.push_back(W'(7));
        sum_q.push_back(W'(15));
        sum_track = 1;
        repeat (3) @(negedge clock);
        hold = 0;
        wait_done();
        sum_track = 0;
        chk("drain_steps_seen", 64'(sum_q.size()), 64'(0));

        // Empty range with in_last.
        do_reset();
        pulse_en();
        push_done(W'(0), 1'b0, 1);
        send(W'(50), W'(40), 1'b1, -1, W'(0));
        wait_done();

        // Overflow, then restart from S_DONE.
        lat = 2;
        pulse_en();
        push_done(W'(1), 1'b1, 2);
        send(W'(1), W'(2), 1'b0, 0, {W{1'b1}});
        send(W'(3), W'(4), 1'b1, 1, W'(2));
        wait_done();
        pulse_en();
        chk("restart_id_sum", 64'(id_sum), 64'(0));
        chk("restart_overflow", 64'(overflow), 64'(0));
        chk("restart_done", 64'(done), 64'(0));
        chk("restart_count", 64'(range_count), 64'(0));
        push_done(W'(7), 1'b0, 1);
        send(W'(5), W'(6), 1'b1, 0, W'(7));
        wait_done();

        // Reset mid-job, then late completions flag a protocol error.
        do_reset();
        lat = 30;
        pulse_en();
        send(W'(200), W'(210), 1'b0, 0, W'(5));
        send(W'(220), W'(230), 1'b0, 1, W'(5));
        send(W'(240), W'(250), 1'b0, 2, W'(5));
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("midrst_id_sum", 64'(id_sum), 64'(0));
        chk("midrst_count", 64'(range_count), 64'(0));
        chk("midrst_in_ready", 64'(bus.in_ready), 64'(0));
        chk("midrst_disp_valid", 64'(bus.disp_valid), 64'(0));
        chk("midrst_done", 64'(done), 64'(0));
        chk("midrst_proto_err", 64'(proto_err), 64'(0));
        reset = 1'b0;
        n = 0;
        while (!proto_err && n < 60) begin
            @(negedge clock);
            n++;
        end
        chk("late_done_proto_err", 64'(proto_err), 64'(1));
        chk("late_done_id_sum", 64'(id_sum), 64'(0));

        chk("disp_q_drained", 64'(disp_q.size()), 64'(0));
        chk("done_q_drained", 64'(done_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
